// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared types and helpers for the key conditioning block:
//               per-key FSM state encoding, tick divider derivation and
//               counter width calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

  // Per-key hold/repeat state machine encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } key_state_e;

  // Number of clk cycles per 1 ms tick.
  localparam int TICKS_PER_SECOND = 1000;

  function automatic int tick_div(input int clk_hz);
    return clk_hz / TICKS_PER_SECOND;
  endfunction

  // Width of a counter holding 0 .. max_count-1 (it is cleared at its
  // terminal count, so max_count itself is never stored). Minimum 1 bit.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner_if
// Description : Raw key inputs and conditioned per-key level/pulse outputs.
//               slave  = the conditioner, master = the raw-key source / user.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_conditioner_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_repeat;

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_long, key_repeat
  );

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_long, key_repeat
  );
endinterface
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// ============================================================================
// Module      : key_channel
// Description : One key: 2-flop synchroniser, polarity normalisation,
//               debounce counter, IDLE/PRESSED/HELD FSM and registered
//               press/release/long/repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DEB_W    = cnt_width(DEBOUNCE_MS);
  localparam int HOLD_W   = cnt_width(max_int(LONG_MS, REPEAT_MS));
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = (REPEAT_MS == 0) ? '0 : HOLD_W'(REPEAT_MS - 1);
  // Raw level of a released key; the synchroniser presets to it so a key
  // held through reset looks like a fresh press afterwards.
  localparam logic RAW_IDLE = (KEY_ACTIVE_LOW != 0);

  logic              sync1_d, sync1_q, sync2_d, sync2_q;
  logic              pressed_w;
  logic [DEB_W-1:0]  deb_d, deb_q;
  logic              level_d, level_q;
  logic              press_d, press_q, release_d, release_q;
  logic              long_d, long_q, repeat_d, repeat_q;
  logic [HOLD_W-1:0] hold_d, hold_q;
  key_state_e        state_d, state_q;

  assign pressed_w = sync2_q ^ RAW_IDLE;

  // Next-state logic: synchroniser shift, debounce, edge pulses, hold FSM.
  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    level_d   = level_q;
    if (pressed_w == level_q) begin
      deb_d = '0;
    end else if (tick) begin
      if (deb_q == DEB_LAST) begin
        deb_d   = '0;
        level_d = ~level_q;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;

    state_d  = state_q;
    hold_d   = hold_q;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_d) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (release_d) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = ST_HELD;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_HELD: begin
        if (release_d) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if ((REPEAT_MS != 0) && tick) begin
          if (hold_q == REP_LAST) begin
            repeat_d = 1'b1;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= RAW_IDLE;
      sync2_q   <= RAW_IDLE;
      deb_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      hold_q    <= '0;
      state_q   <= ST_IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_repeat  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner
// Description : Push-button conditioner. Owns the shared 1 ms tick prescaler
//               and instantiates one independent key_channel per key.
// Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS         = 2,
  parameter int CLK_HZ         = 12000000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  key_conditioner_if.slave        kif
);

  localparam int TICK_DIV = tick_div(CLK_HZ);

  logic tick;

  generate
    if (TICK_DIV <= 1) begin : g_tick_always
      assign tick = 1'b1;
    end else begin : g_tick_prescaler
      localparam int PRE_W = cnt_width(TICK_DIV);
      localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
      logic [PRE_W-1:0] pre_d, pre_q;

      // Free-running divider, cleared at its terminal count.
      always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      end

      // Prescaler register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_q <= '0;
        else      pre_q <= pre_d;
      end

      assign tick = (pre_q == PRE_LAST);
    end
  endgenerate

  logic [N_KEYS-1:0] level_w, press_w, release_w, long_w, repeat_w;

  generate
    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_channel #(
        .DEBOUNCE_MS    (DEBOUNCE_MS),
        .LONG_MS        (LONG_MS),
        .REPEAT_MS      (REPEAT_MS),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .key_raw     (kif.key_in[i]),
        .key_level   (level_w[i]),
        .key_press   (press_w[i]),
        .key_release (release_w[i]),
        .key_long    (long_w[i]),
        .key_repeat  (repeat_w[i])
      );
    end
  endgenerate

  assign kif.key_level   = level_w;
  assign kif.key_press   = press_w;
  assign kif.key_release = release_w;
  assign kif.key_long    = long_w;
  assign kif.key_repeat  = repeat_w;

endmodule
`default_nettype wire

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input conditioning stage for the board's push-buttons, placed directly upstream of the operand-entry/mode FSM.
- Takes raw, bouncing, asynchronous key inputs and synchronises and debounces each one independently.
- Per key it emits a clean level plus single-cycle press, release, long-press and auto-repeat pulses.
- Downstream logic consumes only these one-cycle pulses and never sees raw switch edges.

Parameters:
- N_KEYS, 2: number of independent key channels.
- CLK_HZ, 12000000: clk frequency. TICK_DIV = CLK_HZ/1000 must be ≥1.
- DEBOUNCE_MS, 20: stable time in ms ticks required to accept a level change. Must be ≥1.
- LONG_MS, 1000: hold time in ticks after the accepted press before key_long fires. Must be ≥1.
- REPEAT_MS, 200: interval in ticks between key_repeat pulses after key_long. 0 disables repeat.
- KEY_ACTIVE_LOW, 1: 1 means a raw input of 0 is "pressed".

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_in  in  N_KEYS  raw button inputs, asynchronous to clk.
- key_level  out  N_KEYS  debounced state, 1 = pressed.
- key_press  out  N_KEYS  1-cycle pulse when an accepted press occurs.
- key_release  out  N_KEYS  1-cycle pulse when an accepted release occurs.
- key_long  out  N_KEYS  1-cycle pulse once per press, when the hold reaches LONG_MS.
- key_repeat  out  N_KEYS  1-cycle pulse every REPEAT_MS ticks after key_long while still held.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Synchroniser flops are preset to the "released" raw level, so a key held through reset cannot produce a spurious pulse.
  - Prescaler, debounce counters and hold counters are 0; every FSM is in IDLE.
- Tick: a shared prescaler asserts tick for 1 clk every TICK_DIV cycles. When TICK_DIV=1, tick is always 1.
- Synchroniser:
  - 2-flop synchroniser per key, then polarity normalisation to 1 = pressed.
  - A raw change at edge k is visible as sync at edge k+2.
- Debounce, per key:
  - The counter is cleared whenever sync == key_level.
  - On each tick with sync != key_level, the counter increments.
  - When the counter would reach DEBOUNCE_MS, key_level toggles and the counter clears.
  - Any glitch that returns to the stable level before DEBOUNCE_MS ticks causes no output change.
  - With TICK_DIV=1: raw change at edge k → key_level changes at edge k+2+DEBOUNCE_MS.
- Edge pulses:
  - key_press is registered at the same edge where key_level goes 0→1; key_release likewise on 1→0.
  - Each is high for exactly 1 cycle.
- Per-key FSM states: IDLE, PRESSED, HELD.
  - IDLE→PRESSED on an accepted press; hold counter cleared.
  - PRESSED: the hold counter increments each tick. When it reaches LONG_MS, key_long pulses, state becomes HELD and the counter clears.
  - HELD: if REPEAT_MS≠0, the counter increments each tick. Each time it reaches REPEAT_MS, key_repeat pulses and the counter clears.
  - PRESSED or HELD → IDLE on an accepted release. key_release pulses; no long or repeat fires in that cycle or afterwards.
- Timing with TICK_DIV=1: level rises at edge E → key_long at E+LONG_MS → key_repeat at E+LONG_MS+n·REPEAT_MS for n=1,2,…
- Counters:
  - Widths come from $clog2 of their maxima.
  - No counter wraps, because each is cleared at its terminal count.
- Channels are fully independent:
  - Simultaneous events on different keys produce simultaneous pulses.
  - There is no priority or masking between keys.
- Reset mid-operation:
  - All state is lost and outputs drop immediately.
  - A key still held when rst deasserts is treated as a fresh press: full sync + debounce latency, then key_press. key_long timing restarts from zero.

Decomposition:
- Shared package (key_pkg):
  - FSM state enum {IDLE, PRESSED, HELD}.
  - TICK_DIV derivation.
  - Counter-width localparams.
- Sub-module key_channel:
  - Contains one key's synchroniser, debounce counter, FSM and pulse registers.
  - key_conditioner instantiates it N_KEYS times via generate and owns only the shared tick prescaler.

Test Plan (bench parameters: CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=10, REPEAT_MS=3, N_KEYS=2, active-low):
1. Reset behaviour: hold rst=0 with key_in=2'b11 → all outputs 0. Release rst and idle 50 cycles → no pulse on any output.
2. Clean press: key_in[0]=0 at edge k and held → key_level[0] and key_press[0] rise at k+6. key_press[0] is low at k+7. Key 1 outputs stay 0.
3. Bounce rejection: key_in[0] toggles low 3 cycles, high 1, low 3, high 1, then high → key_level[0], key_press[0] and key_release[0] stay 0 throughout.
4. Long press with repeat:
   - Stimulus: key_in[0]=0 at k, then back to 1 at k+30.
   - key_press at k+6, key_long at k+16.
   - key_repeat at k+19, 22, 25, 28, 31, 34.
   - key_release at k+36; no further repeat after k+36.
5. Simultaneous keys: key_in=2'b00 at edge k → key_press=2'b11 at k+6. Then key_in[1]=1 at k+8 → key_release[1] at k+14, while key_level[0] stays 1.
6. Reset mid-hold: key0 held until HELD is reached. Assert rst → all outputs 0 immediately. Deassert rst at edge r with key still low → key_press[0] at r+6 and key_long[0] at r+16.
